// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-filtered start detect, 3-sample majority vote per bit,
// rdy/rdy_clr word handoff with parity, framing and overrun status.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic                 clken,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_POST = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_param: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   prev_s;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bitpos;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   scratch;
    logic                   s_pre;
    logic                   s_mid;
    logic                   perr;
    logic                   ferr;
    logic                   vote;

    // Only meaningful at CNT_POST, when s_pre/s_mid hold the two earlier samples of this bit.
    assign vote = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            prev_s     <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bitpos     <= '0;
            stop_idx   <= 1'b0;
            scratch    <= '0;
            s_pre      <= 1'b0;
            s_mid      <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            rdy        <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            if (rdy_clr) begin
                rdy        <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (!rx_en) begin
                state    <= S_IDLE;
                cnt      <= '0;
                bitpos   <= '0;
                stop_idx <= 1'b0;
                scratch  <= '0;
            end else if (clken) begin
                if (state != S_IDLE) begin
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                    if (cnt == CNT_PRE) s_pre <= rx_s;
                    if (cnt == CNT_MID) s_mid <= rx_s;
                end

                case (state)
                    S_IDLE: begin
                        prev_s <= rx_s;
                        if (prev_s && !rx_s) begin
                            state <= S_START;
                            cnt   <= CW'(1);
                            perr  <= 1'b0;
                            ferr  <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (cnt == CNT_POST && vote) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= S_DATA;
                            bitpos <= '0;
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_POST) scratch[bitpos] <= vote;
                        if (cnt == CNT_LAST) begin
                            if (bitpos == BIT_LAST) begin
                                bitpos   <= '0;
                                stop_idx <= 1'b0;
                                state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bitpos <= bitpos + BW'(1);
                            end
                        end
                    end
                    S_PARITY: begin
                        if (cnt == CNT_POST) perr <= ((^scratch) ^ vote) != (PARITY == 1);
                        if (cnt == CNT_LAST) begin
                            state    <= S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (cnt == CNT_POST) begin
                            if (!vote) ferr <= 1'b1;
                            if (stop_idx == STOP_LAST) begin
                                data       <= scratch;
                                rdy        <= 1'b1;
                                parity_err <= perr;
                                frame_err  <= ferr | ~vote;
                                overrun    <= rdy & ~rdy_clr;
                                state      <= S_IDLE;
                                cnt        <= '0;
                                stop_idx   <= 1'b0;
                                // A low stop bit leaves prev_s low, so a held break cannot retrigger.
                                prev_s     <= vote;
                            end
                        end else if (cnt == CNT_LAST) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance plus a 7E1 instance, clken every 4th clock.
`timescale 1ns/1ps
module tb_uart_rx_param;
    logic       clk_50m = 1'b0;
    logic       rst_n, rx, rx7, rx_en, clken, rdy_clr;
    logic       rdy, parity_err, frame_err, overrun, busy;
    logic [7:0] data;
    logic       rdy7, perr7, ferr7, ovr7, busy7;
    logic [6:0] data7;
    int         checks = 0;
    int         errors = 0;
    int         div = 0;
    int         rt;
    logic       br;

    uart_rx_param dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .rx(rx), .rx_en(rx_en), .clken(clken),
        .rdy_clr(rdy_clr), .rdy(rdy), .data(data), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut7 (
        .clk_50m(clk_50m), .rst_n(rst_n), .rx(rx7), .rx_en(rx_en), .clken(clken),
        .rdy_clr(rdy_clr), .rdy(rdy7), .data(data7), .parity_err(perr7),
        .frame_err(ferr7), .overrun(ovr7), .busy(busy7)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        clken = 1'b0;
        forever begin
            @(negedge clk_50m);
            div   = (div + 1) % 4;
            clken = (div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk_50m);
        while (!clken) @(posedge clk_50m);
        #1;
    endtask

    task automatic idle(input int n);
        rx  = 1'b1;
        rx7 = 1'b1;
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic clr();
        rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        rdy_clr = 1'b0;
    endtask

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stp);
        return {6'b111111, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7(input logic [6:0] d, input logic p, input logic stp);
        return {6'b111111, stp, p, d, 1'b0};
    endfunction

    // Drives nbits x 16 ticks; tick 0 is the detect tick. clr_t raises rdy_clr on that tick's edge only.
    task automatic send_frame(input bit sel7, input logic [15:0] bits, input int nbits,
                              input int spike_t, input int clr_t,
                              output int rise_t, output logic busy_at_rise);
        logic prev_r, cur_r, v;
        prev_r       = sel7 ? rdy7 : rdy;
        rise_t       = -1;
        busy_at_rise = 1'b1;
        for (int t = 0; t < nbits * 16; t++) begin
            v = bits[t / 16];
            if (t == spike_t) v = ~v;
            if (sel7) rx7 = v; else rx = v;
            if (t == clr_t) begin
                repeat (3) @(posedge clk_50m);
                #1;
                rdy_clr = 1'b1;
            end
            wait_tick();
            if (t == clr_t) rdy_clr = 1'b0;
            cur_r = sel7 ? rdy7 : rdy;
            if (!prev_r && cur_r && rise_t < 0) begin
                rise_t       = t;
                busy_at_rise = sel7 ? busy7 : busy;
            end
            prev_r = cur_r;
        end
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; rx7 = 1'b1; rx_en = 1'b1; rdy_clr = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_rdy", rdy, 0);
        check("rst_data", data, 0);
        check("rst_flags", {parity_err, frame_err, overrun}, 0);
        check("rst_busy", busy, 0);
        check("rst_busy7", busy7, 0);
        rst_n = 1'b1;
        idle(4);

        send_frame(0, f8(8'hA5, 1'b1), 10, -1, -1, rt, br);
        check("a5_latency", rt, 153);
        check("a5_busy_at_rdy", br, 0);
        check("a5_data", data, 8'hA5);
        check("a5_flags", {parity_err, frame_err, overrun}, 0);
        clr();
        check("clr_rdy", rdy, 0);

        for (int t = 0; t < 10; t++) begin
            rx = (t < 3) ? 1'b0 : 1'b1;
            wait_tick();
            if (t == 0) check("glitch_busy_c0", busy, 1);
            if (t == 8) check("glitch_busy_c8", busy, 1);
            if (t == 9) check("glitch_busy_c9", busy, 0);
        end
        check("glitch_no_rdy", rdy, 0);
        idle(4);
        send_frame(0, f8(8'h3C, 1'b1), 10, -1, -1, rt, br);
        check("post_glitch_data", data, 8'h3C);
        check("post_glitch_rdy", rdy, 1);
        clr();

        idle(2);
        send_frame(0, f8(8'h00, 1'b1), 10, 24, -1, rt, br);
        check("noise_data", data, 8'h00);
        check("noise_rdy", rdy, 1);
        clr();

        send_frame(1, f7(7'h35, 1'b0, 1'b1), 10, -1, -1, rt, br);
        check("e71_latency", rt, 153);
        check("e71_data", data7, 7'h35);
        check("e71_perr", perr7, 0);
        clr();
        send_frame(1, f7(7'h35, 1'b1, 1'b1), 10, -1, -1, rt, br);
        check("e71_bad_data", data7, 7'h35);
        check("e71_bad_perr", perr7, 1);
        check("e71_bad_ferr", ferr7, 0);
        clr();

        send_frame(0, f8(8'h81, 1'b0), 10, -1, -1, rt, br);
        check("brk_ferr", frame_err, 1);
        check("brk_data", data, 8'h81);
        check("brk_rdy", rdy, 1);
        clr();
        for (int i = 0; i < 640; i++) wait_tick();
        check("brk_hold_rdy", rdy, 0);
        check("brk_hold_busy", busy, 0);
        check("brk_hold_data", data, 8'h81);
        idle(4);
        send_frame(0, f8(8'h5A, 1'b1), 10, -1, -1, rt, br);
        check("post_brk_data", data, 8'h5A);
        check("post_brk_ferr", frame_err, 0);
        clr();

        send_frame(0, f8(8'h11, 1'b1), 10, -1, -1, rt, br);
        send_frame(0, f8(8'h22, 1'b1), 10, -1, -1, rt, br);
        check("ovr_flag", overrun, 1);
        check("ovr_data", data, 8'h22);
        clr();
        check("ovr_clr", {rdy, parity_err, frame_err, overrun}, 0);

        send_frame(0, f8(8'h33, 1'b1), 10, -1, -1, rt, br);
        send_frame(0, f8(8'h44, 1'b1), 10, -1, 153, rt, br);
        check("clr_commit_rdy", rdy, 1);
        check("clr_commit_ovr", overrun, 0);
        check("clr_commit_data", data, 8'h44);
        clr();

        send_frame(0, f8(8'h0F, 1'b1), 4, -1, -1, rt, br);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_data", data, 0);
        @(posedge clk_50m);
        #1;
        rst_n = 1'b1;
        idle(4);
        check("midrst_no_rdy", rdy, 0);
        send_frame(0, f8(8'h96, 1'b1), 10, -1, -1, rt, br);
        check("midrst_next_data", data, 8'h96);
        clr();

        send_frame(0, f8(8'hF0, 1'b1), 4, -1, -1, rt, br);
        check("dis_busy_before", busy, 1);
        rx_en = 1'b0;
        repeat (2) @(posedge clk_50m);
        #1;
        check("dis_busy", busy, 0);
        rx_en = 1'b1;
        idle(4);
        check("dis_no_rdy", rdy, 0);
        check("dis_data_held", data, 8'h96);
        send_frame(0, f8(8'h69, 1'b1), 10, -1, -1, rt, br);
        check("dis_next_data", data, 8'h69);
        check("dis_next_flags", {rdy, parity_err, frame_err, overrun}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
